// File: rtl/status_flag_register.sv
// status_flag_register: produces the committed N/Z/C/V flags for the condition
// tester. Candidate flags come from the ALU/shifter outputs and the opcode,
// pass through a one-entry pending stage, and commit one edge later. A shadow
// copy supports exception entry/return, and FlagWrite gives a direct write.
//
// Ports:
//   Clk, Reset                  clock, asynchronous active-high reset
//   AluResult[DATA_WIDTH-1:0]   ALU result (N = MSB, Z = all zero)
//   AluCarry, AluOverflow       ALU carry (NOT borrow for SUB) and signed overflow
//   ShifterCarry                shifter carry out, used by logical opcodes
//   OpCode[3:0], SBit           data-processing opcode and S bit
//   CondPass, Load              condition-test result and capture strobe
//   FlagWrite, FlagIn[3:0]      direct write of {N,Z,C,V}
//   Save, Restore               flags -> shadow, shadow -> flags
//   N, Z, C, V                  committed flags (registered)
//   Shadow[3:0]                 shadow copy {N,Z,C,V} (registered)
//   FlagsValid                  high when no capture is pending (registered)
module status_flag_register #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] AluResult,
    input  logic                  AluCarry,
    input  logic                  AluOverflow,
    input  logic                  ShifterCarry,
    input  logic [3:0]            OpCode,
    input  logic                  SBit,
    input  logic                  CondPass,
    input  logic                  Load,
    input  logic                  FlagWrite,
    input  logic [3:0]            FlagIn,
    input  logic                  Save,
    input  logic                  Restore,
    output logic                  N,
    output logic                  Z,
    output logic                  C,
    output logic                  V,
    output logic [3:0]            Shadow,
    output logic                  FlagsValid
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] flags;
    logic [3:0] pend;
    logic [3:0] shadow_q;
    logic       valid_q;

    logic       upd;
    logic       is_arith;
    logic       v_keep;
    logic [3:0] cand;

    // Compare/test opcodes (8-B) always set flags; others need the S bit.
    always_comb begin
        upd = Load & CondPass & (SBit | (OpCode[3:2] == 2'b10));
    end

    // Arithmetic opcodes take C/V from the ALU; logical ones keep V.
    always_comb begin
        is_arith = 1'b0;
        case (OpCode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB: is_arith = 1'b1;
            default:                                         is_arith = 1'b0;
        endcase
    end

    // When a commit happens on the same edge as a new capture, the V being
    // kept is the one about to be committed, not the stale committed V.
    always_comb begin
        v_keep = (state == PENDING) ? pend[0] : flags[0];
        cand   = {AluResult[DATA_WIDTH-1],
                  (AluResult == '0),
                  is_arith ? AluCarry    : ShifterCarry,
                  is_arith ? AluOverflow : v_keep};
    end

    // State, pending stage, committed flags and shadow.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            pend     <= 4'b0000;
            flags    <= RESET_FLAGS;
            shadow_q <= RESET_FLAGS;
            valid_q  <= 1'b1;
        end else begin
            // Shadow always sees the flags as they were before this edge,
            // so Save with Restore swaps the two.
            if (Save) begin
                shadow_q <= flags;
            end

            if (Restore) begin
                flags   <= shadow_q;
                state   <= IDLE;
                valid_q <= 1'b1;
            end else if (FlagWrite) begin
                flags   <= FlagIn;
                state   <= IDLE;
                valid_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (upd) begin
                            pend    <= cand;
                            state   <= PENDING;
                            valid_q <= 1'b0;
                        end
                    end
                    PENDING: begin
                        flags <= pend;
                        if (upd) begin
                            pend    <= cand;
                            state   <= PENDING;
                            valid_q <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign {N, Z, C, V} = flags;
    assign Shadow       = shadow_q;
    assign FlagsValid   = valid_q;

endmodule

// File: tb/tb_status_flag_register.sv
// Directed bench for status_flag_register. Stimulus drives one vector per
// cycle on the falling edge and queues the hand-computed outputs expected
// after the next rising edge; an independent monitor pops and compares.
module tb_status_flag_register;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result;
    logic        alu_carry, alu_overflow, shifter_carry;
    logic [3:0]  opcode;
    logic        sbit, cond_pass, load, flag_write, save, restore;
    logic [3:0]  flag_in;
    logic        n, z, c, v, flags_valid;
    logic [3:0]  shadow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [3:0] f;
        logic [3:0] s;
        logic       vld;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    status_flag_register #(.DATA_WIDTH(32), .RESET_FLAGS(4'b0000)) dut (
        .Clk(clk), .Reset(rst), .AluResult(alu_result), .AluCarry(alu_carry),
        .AluOverflow(alu_overflow), .ShifterCarry(shifter_carry), .OpCode(opcode),
        .SBit(sbit), .CondPass(cond_pass), .Load(load), .FlagWrite(flag_write),
        .FlagIn(flag_in), .Save(save), .Restore(restore), .N(n), .Z(z), .C(c),
        .V(v), .Shadow(shadow), .FlagsValid(flags_valid)
    );

    task automatic cmp(input string nm, input logic [3:0] ef, input logic [3:0] es,
                       input logic ev);
        logic [8:0] act;
        logic [8:0] req;
        act = {n, z, c, v, shadow, flags_valid};
        req = {ef, es, ev};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got flags=%b shadow=%b valid=%b, expected flags=%b shadow=%b valid=%b",
                     nm, act[8:5], act[4:1], act[0], ef, es, ev);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic vec(input string nm, input logic ld, input logic sb, input logic cp,
                       input logic [3:0] op, input logic [31:0] res, input logic ac,
                       input logic ao, input logic sc, input logic fw,
                       input logic [3:0] fin, input logic sv, input logic rs,
                       input logic [3:0] ef, input logic [3:0] es, input logic ev);
        exp_t e;
        @(negedge clk);
        load = ld; sbit = sb; cond_pass = cp; opcode = op; alu_result = res;
        alu_carry = ac; alu_overflow = ao; shifter_carry = sc;
        flag_write = fw; flag_in = fin; save = sv; restore = rs;
        e.nm = nm; e.f = ef; e.s = es; e.vld = ev;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [3:0] ef, input logic [3:0] es,
                        input logic ev);
        vec(nm, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 4'h0, 0, 0, ef, es, ev);
    endtask

    // Monitor: compare queued expectations shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.nm, e.f, e.s, e.vld);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        load = 0; sbit = 0; cond_pass = 0; opcode = 4'h0; alu_result = 32'h0;
        alu_carry = 0; alu_overflow = 0; shifter_carry = 0;
        flag_write = 0; flag_in = 4'h0; save = 0; restore = 0;
        @(posedge clk);
        #1;
        cmp("reset_state", 4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        //  name              ld sb cp op    result        ac ao sc fw fin    sv rs  flags    shadow   valid
        vec("adds_zero",      1, 1, 1, 4'h4, 32'h00000000, 1, 0, 0, 0, 4'h0, 0, 0, 4'b0000, 4'b0000, 0);
        idle("adds_commit",                                                      4'b0110, 4'b0000, 1);
        vec("subs",           1, 1, 1, 4'h2, 32'h00000001, 1, 1, 0, 0, 4'h0, 0, 0, 4'b0110, 4'b0000, 0);
        vec("ands_b2b",       1, 1, 1, 4'h0, 32'h00000001, 0, 0, 0, 0, 4'h0, 0, 0, 4'b0011, 4'b0000, 0);
        idle("ands_v_fwd",                                                       4'b0001, 4'b0000, 1);
        vec("mov_no_s",       1, 0, 1, 4'hD, 32'h00000000, 0, 0, 1, 0, 4'h0, 0, 0, 4'b0001, 4'b0000, 1);
        vec("cmp_no_s",       1, 0, 1, 4'hA, 32'h80000000, 0, 1, 0, 0, 4'h0, 0, 0, 4'b0001, 4'b0000, 0);
        idle("cmp_commit",                                                       4'b1001, 4'b0000, 1);
        vec("cond_fail",      1, 1, 0, 4'h4, 32'h00000000, 1, 0, 0, 0, 4'h0, 0, 0, 4'b1001, 4'b0000, 1);
        idle("cond_fail_hold",                                                   4'b1001, 4'b0000, 1);
        vec("adds_pend",      1, 1, 1, 4'h4, 32'h00000000, 1, 0, 0, 0, 4'h0, 0, 0, 4'b1001, 4'b0000, 0);
        vec("fw_in_pending",  1, 1, 1, 4'h4, 32'h00000000, 1, 0, 0, 1, 4'hC, 0, 0, 4'b1100, 4'b0000, 1);
        idle("fw_discarded",                                                     4'b1100, 4'b0000, 1);
        vec("fw_0101",        0, 0, 0, 4'h0, 32'h00000000, 0, 0, 0, 1, 4'h5, 0, 0, 4'b0101, 4'b0000, 1);
        vec("save",           0, 0, 0, 4'h0, 32'h00000000, 0, 0, 0, 0, 4'h0, 1, 0, 4'b0101, 4'b0101, 1);
        vec("fw_1010",        0, 0, 0, 4'h0, 32'h00000000, 0, 0, 0, 1, 4'hA, 0, 0, 4'b1010, 4'b0101, 1);
        vec("save_restore",   0, 0, 0, 4'h0, 32'h00000000, 0, 0, 0, 0, 4'h0, 1, 1, 4'b0101, 4'b1010, 1);
        idle("swap_hold",                                                        4'b0101, 4'b1010, 1);
        vec("save_with_fw",   0, 0, 0, 4'h0, 32'h00000000, 0, 0, 0, 1, 4'hF, 1, 0, 4'b1111, 4'b0101, 1);
        vec("adds_pend2",     1, 1, 1, 4'h4, 32'h00000000, 1, 0, 0, 0, 4'h0, 0, 0, 4'b1111, 4'b0101, 0);
        vec("restore_pend",   1, 1, 1, 4'h4, 32'h00000000, 1, 0, 0, 1, 4'h0, 0, 1, 4'b0101, 4'b0101, 1);
        idle("restore_hold",                                                     4'b0101, 4'b0101, 1);
        vec("pend_1010",      1, 1, 1, 4'h4, 32'h80000000, 1, 0, 0, 0, 4'h0, 0, 0, 4'b0101, 4'b0101, 0);

        // Asynchronous reset while 1010 is pending, released before the next edge.
        @(negedge clk);
        load = 0; sbit = 0; cond_pass = 0; opcode = 4'h0; alu_result = 32'h0;
        alu_carry = 0; alu_overflow = 0; shifter_carry = 0;
        flag_write = 0; flag_in = 4'h0; save = 0; restore = 0;
        rst = 1'b1;
        #1;
        cmp("reset_mid_pending", 4'b0000, 4'b0000, 1'b1);
        #1;
        rst = 1'b0;
        idle("post_reset_edge",                                                  4'b0000, 4'b0000, 1);

        @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_flag_register.md
Name: status_flag_register

Overview:
- Producer of the N, Z, C, V flags that the condition tester consumes; sits between the ALU/shifter datapath and the condition tester in the ARM simulator datapath.
- Derives candidate flags from the ALU result, the ALU carry/overflow, the shifter carry and the data-processing opcode.
- Commits flags through a one-entry pending stage, under control of control-register strobes.
- Provides a one-entry shadow copy of the flags for exception entry and return, plus a direct flag write for MSR-style microinstructions.

Parameters:
- DATA_WIDTH, 32, width of the ALU result bus; N is taken from bit DATA_WIDTH-1.
- RESET_FLAGS, 4'b0000, value of {N,Z,C,V} and of the shadow after reset.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- AluResult  input  DATA_WIDTH  ALU result for the current microinstruction.
- AluCarry  input  1  ALU carry out (for SUB-type opcodes, carry = NOT borrow).
- AluOverflow  input  1  ALU signed overflow.
- ShifterCarry  input  1  shifter carry out.
- OpCode  input  4  ARM data-processing opcode, instruction bits 24:21.
- SBit  input  1  instruction S bit.
- CondPass  input  1  Cond output of the condition tester for the current instruction.
- Load  input  1  control-register strobe: evaluate and capture flags this cycle.
- FlagWrite  input  1  direct write of FlagIn into the flags.
- FlagIn  input  4  {N,Z,C,V} for FlagWrite.
- Save  input  1  copy the committed flags into the shadow.
- Restore  input  1  copy the shadow into the committed flags.
- N, Z, C, V  output  1 each  committed flags (registered).
- Shadow  output  4  shadow copy, ordered {N,Z,C,V}.
- FlagsValid  output  1  high when no capture is pending.

Behaviour:
- Reset (asynchronous, any time, including with a capture pending):
  - {N,Z,C,V} = RESET_FLAGS; Shadow = RESET_FLAGS.
  - Pending stage cleared; FlagsValid = 1.
- Update qualifier: upd = Load & CondPass & (SBit | OpCode[3:2]==2'b10).
  - TST, TEQ, CMP and CMN (opcodes 8–B) update flags regardless of SBit.
- Logical opcodes 0, 1, 8, 9, C, D, E, F:
  - N = AluResult[MSB].
  - Z = (AluResult == 0).
  - C = ShifterCarry.
  - V = current committed V (unchanged).
- Arithmetic opcodes 2–7, A, B:
  - N = AluResult[MSB].
  - Z = (AluResult == 0).
  - C = AluCarry.
  - V = AluOverflow.
- Two-state FSM, IDLE and PENDING:
  - IDLE --(upd)--> PENDING: the candidate {N,Z,C,V} is captured into the pending register at that edge.
  - PENDING --(no upd)--> IDLE: the pending value is committed to N/Z/C/V at that edge.
  - PENDING --(upd)--> PENDING: pending commits and the new candidate is captured at the same edge. For a logical op in this case, V comes from the value being committed (forwarded), not the stale V.
  - Net latency: flags are visible on the outputs 2 edges after the Load edge.
  - FlagsValid = (state == IDLE), registered with the state.
- Load with upd = 0: no capture; the FSM still advances as if upd were low.
- Priority per edge, highest first:
  1. Reset.
  2. Restore: flags ← Shadow; pending discarded; state → IDLE; simultaneous FlagWrite and upd are ignored.
  3. FlagWrite: flags ← FlagIn; pending discarded; state → IDLE; simultaneous upd is ignored.
  4. Normal FSM operation.
- Save:
  - Shadow ← committed flags as they were before this edge. A same-edge commit or write is not seen by the shadow.
  - Save and Restore together: the flags and the shadow swap values.
- Outputs never glitch combinationally; all of them come straight from flops.

Test Plan:
- Reset mid-PENDING (after an upd capture of 4'b1010 is in flight) -> all outputs immediately RESET_FLAGS, FlagsValid=1, and the flags stay RESET_FLAGS on the next edge.
- ADD (op 4), SBit=1, CondPass=1, AluResult=0, AluCarry=1, AluOverflow=0 -> FlagsValid=0 for 1 cycle, then {N,Z,C,V}=0110 two edges after Load.
- MOV (op D), SBit=0, Load=1 -> no change, FlagsValid stays 1. CMP (op A), SBit=0, AluResult=32'h80000000, AluCarry=0, AluOverflow=1 -> flags 1001.
- Back-to-back: SUBS producing 0011, then next cycle ANDS with AluResult=1 and ShifterCarry=0 -> flags 0011, then 0001 (V forwarded from the committing value).
- CondPass=0 with SBit=1 -> flags unchanged. FlagWrite of 4'b1100 during PENDING -> flags=1100, pending discarded, FlagsValid=1.
- Flags=0101, Save -> Shadow=0101. FlagWrite 1010, then Save+Restore on the same edge -> flags=0101 and Shadow=1010.
